// File: rtl/aes_enc_iter_ctrl.sv
// Iterative AES-256 encryption engine: a single shared round datapath stepping one round per clock,
// with a held 256-bit key and valid/ready (plaintext) / valid/yumi (ciphertext) handshakes.
module aes_enc_iter_ctrl #(
    parameter int nr_p = 14
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         key_v_i,
    input  logic [255:0] key_i,
    output logic         key_ready_o,
    input  logic         v_i,
    input  logic [127:0] pt_i,
    output logic         ready_o,
    output logic         v_o,
    output logic [127:0] ct_o,
    input  logic         yumi_i,
    output logic [1:0]   dbg_fsm_o
);

    if (nr_p != 14) begin : g_bad_nr
        $error("aes_enc_iter_ctrl: only nr_p = 14 (AES-256) is supported");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_e;

    fsm_e           fsm_r;
    logic [255:0]   key_r;
    logic           key_valid_r;
    logic [127:0]   state_r;
    logic [3:0]     rnd_r;
    logic [1919:0]  chain;
    logic [127:0]   rk_cur;
    logic [127:0]   round_out;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (a^254, which maps 0 to 0) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] base;
        logic [7:0] e;
        r    = 8'h01;
        base = a;
        e    = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gf_mul(r, base);
            base = gf_mul(base, base);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Byte i of a block sits at [127-8*i -: 8]; byte index is row + 4*column.
    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] k);
        return s ^ k;
    endfunction

    function automatic logic [127:0] encryption_rounds(input logic [127:0] s, input logic [127:0] k);
        return add_round_key(mix_columns(shift_rows(sub_bytes(s))), k);
    endfunction

    // Full AES-256 schedule: 60 words, word 0 at the MSB end so round key i is chain[1919-128*i -: 128].
    function automatic logic [1919:0] key_expansion(input logic [255:0] k);
        logic [31:0]   w [0:59];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] ch;
        rc = 8'h01;
        ch = '0;
        for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = xtime(rc);
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int i = 0; i < 60; i++) ch[1919-32*i -: 32] = w[i];
        return ch;
    endfunction

    always_comb begin
        chain  = key_expansion(key_r);
        rk_cur = '0;
        for (int i = 0; i < 15; i++) begin
            if (rnd_r == 4'(i)) rk_cur = chain[1919-128*i -: 128];
        end
        if (rnd_r == 4'(nr_p)) round_out = add_round_key(shift_rows(sub_bytes(state_r)), rk_cur);
        else                   round_out = encryption_rounds(state_r, rk_cur);
    end

    // Plaintext moves on v_i & ready_o at a rising edge; ciphertext is taken on yumi_i while v_o=1.
    // A key load has priority over plaintext in IDLE, so ready_o drops whenever key_v_i is high.
    assign key_ready_o = (fsm_r == IDLE);
    assign ready_o     = (fsm_r == IDLE) & key_valid_r & ~key_v_i;
    assign dbg_fsm_o   = fsm_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fsm_r       <= IDLE;
            key_r       <= '0;
            key_valid_r <= 1'b0;
            state_r     <= '0;
            rnd_r       <= 4'd0;
            v_o         <= 1'b0;
            ct_o        <= '0;
        end else begin
            case (fsm_r)
                IDLE: begin
                    if (key_v_i) begin
                        key_r       <= key_i;
                        key_valid_r <= 1'b1;
                    end else if (v_i && ready_o) begin
                        state_r <= add_round_key(pt_i, chain[1919 -: 128]);
                        rnd_r   <= 4'd1;
                        fsm_r   <= ROUND;
                    end
                end
                ROUND: begin
                    state_r <= round_out;
                    if (rnd_r == 4'(nr_p)) begin
                        ct_o  <= round_out;
                        v_o   <= 1'b1;
                        rnd_r <= 4'd0;
                        fsm_r <= DONE;
                    end else begin
                        rnd_r <= rnd_r + 4'd1;
                    end
                end
                DONE: begin
                    if (yumi_i) begin
                        v_o   <= 1'b0;
                        fsm_r <= IDLE;
                    end
                end
                default: fsm_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_enc_iter_ctrl.sv
// Directed bench for aes_enc_iter_ctrl: FIPS-197 AES-256 vectors, latency, backpressure,
// key/plaintext collision and mid-block reset.
module tb_aes_enc_iter_ctrl;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         key_v_i;
    logic [255:0] key_i;
    logic         key_ready_o;
    logic         v_i;
    logic [127:0] pt_i;
    logic         ready_o;
    logic         v_o;
    logic [127:0] ct_o;
    logic         yumi_i;
    logic [1:0]   dbg_fsm_o;

    localparam logic [255:0] KEY1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] KEY0 = 256'h0;
    localparam logic [127:0] PT0  = 128'h0;
    localparam logic [127:0] CT0  = 128'hdc95c078a2408989ad48a21492842087;
    localparam logic [1:0]   S_IDLE  = 2'd0;
    localparam logic [1:0]   S_ROUND = 2'd1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [127:0] exp_q[$];

    aes_enc_iter_ctrl #(.nr_p(14)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .key_v_i     (key_v_i),
        .key_i       (key_i),
        .key_ready_o (key_ready_o),
        .v_i         (v_i),
        .pt_i        (pt_i),
        .ready_o     (ready_o),
        .v_o         (v_o),
        .ct_o        (ct_o),
        .yumi_i      (yumi_i),
        .dbg_fsm_o   (dbg_fsm_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (observed=timeout expected=finish)");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        step();
        step();
        reset_i = 1'b0;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // drivers
    task automatic load_key(input logic [255:0] k);
        key_i   = k;
        key_v_i = 1'b1;
        step();
        key_v_i = 1'b0;
        #1;
    endtask

    task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] ct,
                             input int hold, input bit key_pulse);
        logic [127:0] exp_ct;
        int           wait_n;
        exp_q.push_back(ct);
        pt_i = pt;
        v_i  = 1'b1;
        #1;
        wait_n = 0;
        while (!ready_o && wait_n < 50) begin
            step();
            wait_n++;
        end
        check({tag, "_hs_ready"}, 128'(ready_o), 128'(1'b1));
        step();
        v_i = 1'b0;
        check({tag, "_in_round"}, 128'(dbg_fsm_o), 128'(S_ROUND));
        repeat (13) step();
        check({tag, "_v_early"}, 128'(v_o), 128'(1'b0));
        step();
        check({tag, "_v_lat15"}, 128'(v_o), 128'(1'b1));
        exp_ct = exp_q.pop_front();
        check({tag, "_ct"}, ct_o, exp_ct);
        key_i = KEY0;
        for (int i = 0; i < hold; i++) begin
            key_v_i = key_pulse & ((i % 2) == 0);
            step();
            check({tag, "_hold_v"}, 128'(v_o), 128'(1'b1));
            check({tag, "_hold_ct"}, ct_o, exp_ct);
        end
        key_v_i = 1'b0;
        yumi_i  = 1'b1;
        step();
        yumi_i = 1'b0;
        check({tag, "_v_drop"}, 128'(v_o), 128'(1'b0));
        check({tag, "_ready_back"}, 128'(ready_o), 128'(1'b1));
    endtask

    initial begin
        reset_i = 1'b1;
        key_v_i = 1'b0;
        key_i   = '0;
        v_i     = 1'b0;
        pt_i    = '0;
        yumi_i  = 1'b0;
        do_reset();

        check("rst_v_o", 128'(v_o), 128'(1'b0));
        check("rst_ct_o", ct_o, 128'h0);
        check("rst_key_ready", 128'(key_ready_o), 128'(1'b1));
        check("rst_ready", 128'(ready_o), 128'(1'b0));
        check("rst_fsm", 128'(dbg_fsm_o), 128'(S_IDLE));

        // no key yet: plaintext must be refused, stray yumi ignored
        v_i    = 1'b1;
        pt_i   = PT1;
        yumi_i = 1'b1;
        repeat (5) step();
        yumi_i = 1'b0;
        check("nokey_ready", 128'(ready_o), 128'(1'b0));
        check("nokey_v_o", 128'(v_o), 128'(1'b0));
        check("nokey_fsm", 128'(dbg_fsm_o), 128'(S_IDLE));
        v_i = 1'b0;
        load_key(KEY1);
        check("key_ready_next", 128'(ready_o), 128'(1'b1));

        run_block("vec1", PT1, CT1, 0, 1'b0);

        load_key(KEY0);
        run_block("vec0", PT0, CT0, 0, 1'b0);

        // backpressure with ignored key pulses, then same key must still be in use
        load_key(KEY1);
        run_block("bp", PT1, CT1, 20, 1'b1);
        run_block("bp_after", PT1, CT1, 0, 1'b0);

        // key load and plaintext together: key wins, no block starts
        key_i   = KEY0;
        key_v_i = 1'b1;
        pt_i    = PT0;
        v_i     = 1'b1;
        #1;
        check("coll_ready", 128'(ready_o), 128'(1'b0));
        check("coll_key_ready", 128'(key_ready_o), 128'(1'b1));
        step();
        key_v_i = 1'b0;
        v_i     = 1'b0;
        check("coll_fsm", 128'(dbg_fsm_o), 128'(S_IDLE));
        run_block("coll_newkey", PT0, CT0, 0, 1'b0);

        // reset mid-block
        pt_i = PT1;
        v_i  = 1'b1;
        #1;
        check("abort_ready", 128'(ready_o), 128'(1'b1));
        step();
        v_i = 1'b0;
        repeat (6) step();
        check("abort_pre_fsm", 128'(dbg_fsm_o), 128'(S_ROUND));
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        check("abort_fsm", 128'(dbg_fsm_o), 128'(S_IDLE));
        check("abort_v_o", 128'(v_o), 128'(1'b0));
        check("abort_ct_o", ct_o, 128'h0);
        v_i = 1'b1;
        #1;
        check("abort_keyvalid", 128'(ready_o), 128'(1'b0));
        repeat (16) step();
        check("abort_no_v", 128'(v_o), 128'(1'b0));
        v_i = 1'b0;
        load_key(KEY1);
        run_block("abort_vec1", PT1, CT1, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
